prog_mem_loader: RTL and testbench
==================================

# prog_mem_loader

Parametrised, loadable program memory for the CPU core: a registered instruction-fetch port with a one-cycle request/valid handshake, plus a streaming load port that rewrites the array from address 0 and zero-fills the remainder. At reset the array holds the built-in boot image. The block sits between the fetch stage and the external program loader and replaces the fixed, combinational 32×16 program ROM.

## Interface
Parameters:
- INSTR_W, 16: instruction width in bits. Format is 5-bit opcode, 3-bit register, 8-bit immediate when 16.
- DEPTH, 32: number of instruction words. Any value from 2 to 256; need not be a power of 2.
- ADDR_W, $clog2(DEPTH): address width (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request this cycle.
- fetch_addr  in  ADDR_W  fetch word address.
- fetch_valid  out  1  fetch_instr/fetch_err valid (one-cycle pulse).
- fetch_instr  out  INSTR_W  fetched instruction.
- fetch_err  out  1  requested address ≥ DEPTH.
- load_start  in  1  begin a program load (ignored unless idle).
- load_valid  in  1  load_data valid.
- load_data  in  INSTR_W  next program word.
- load_last  in  1  qualifies load_valid: final word of program.
- load_ready  out  1  loader may present a word.
- busy  out  1  load or clear in progress; fetch blocked.
- load_done  out  1  one-cycle pulse when the array is fully rewritten.
- load_count  out  ADDR_W+1  words written by the current/last load.

## Operation
- Reset (async, rst_n low): array[0] = 0x2810 (00101_000_00010000), array[1] = 0x3900 (00111_001_00000000), all other words 0; FSM = IDLE; all outputs 0.
- FSM states: IDLE, LOAD, CLEAR.
  - IDLE: load_start → LOAD, write pointer = 0, load_count = 0.
  - LOAD: load_ready = 1. On load_valid: write load_data to array[ptr], ptr++, load_count++. If load_last, or ptr was DEPTH-1: go to CLEAR if ptr+1 < DEPTH, else IDLE with load_done.
  - CLEAR: write 0 to array[ptr], one word per cycle, ptr++; after writing DEPTH-1 → IDLE with load_done.
- busy = (state != IDLE). load_start while busy is ignored.
- Fetch: accepted only in IDLE. In LOAD/CLEAR, fetch_req is dropped: no fetch_valid, fetch_instr holds.
- fetch_addr ≥ DEPTH: fetch_valid = 1, fetch_err = 1, fetch_instr = 0 (NOP).
- fetch_instr holds its last value when no fetch is served; fetch_err is valid only with fetch_valid.

## Timing
- Fetch latency is 1 cycle: a request sampled at edge N produces fetch_valid, fetch_instr, and fetch_err in the cycle after N. Back-to-back requests give one result per cycle.
- Simultaneous fetch_req and load_start in IDLE: the fetch is served from the pre-load contents, and the load starts at the same edge.
- A write at edge N is visible to a fetch issued after busy falls; no write-to-read bypass is needed.
- load_done pulses in the first IDLE cycle; busy is 0 in that same cycle.
- A load of K words takes K accepted beats plus (DEPTH−K) CLEAR cycles.
- rst_n asserted mid-load or mid-clear: the boot image is restored immediately and the load is abandoned with no load_done.

## Structure
- cpu_pkg holds INSTR_W default, opcode/reg/imm field widths, BOOT_IMAGE constants (0x2810, 0x3900), and the loader state enum.
- One sub-module is natural: prog_mem_array (register array with reset-to-boot-image, one write port, one registered read port). The FSM and fetch logic live in the top level.

## Test plan
- Reset then fetch addresses 0, 1, 31 → instructions 0x2810, 0x3900, 0x0000, each with fetch_valid exactly one cycle after its request.
- Load 3 words (0xAAAA, 0x5555, 0x1234), with load_last on the third → 29 CLEAR cycles, then a load_done pulse and load_count = 3. Fetch address 2 → 0x1234; fetch address 3 → 0; fetch address 1 → 0x5555.
- Load all 32 words with no load_last → no CLEAR cycles; load_done follows the 32nd beat; fetch 31 → the last word loaded.
- fetch_req during busy → no fetch_valid. load_start during LOAD → ignored, with load_count unaffected. fetch_req + load_start together in IDLE → the old word is returned and busy rises.
- DEPTH=24: fetch address 24 → fetch_err = 1 and fetch_instr = 0; fetch address 23 → fetch_err = 0.
- rst_n pulsed low after 2 load beats → busy = 0 immediately, no load_done, and fetch 0 → 0x2810.

Source files
------------

// File: rtl/prog_mem_loader_pkg.sv
// Shared types and constants for the loadable program memory: instruction fields,
// boot image and loader FSM states.
package prog_mem_loader_pkg;

   localparam int unsigned InstrWDefault = 16;
   localparam int unsigned OpcodeW       = 5;
   localparam int unsigned RegW          = 3;
   localparam int unsigned ImmW          = 8;

   typedef struct packed {
      logic [OpcodeW-1:0] opcode;
      logic [RegW-1:0]    rd;
      logic [ImmW-1:0]    imm;
   } instr_t;

   localparam instr_t BootWord0 = '{opcode: 5'b00101, rd: 3'd0, imm: 8'h10};
   localparam instr_t BootWord1 = '{opcode: 5'b00111, rd: 3'd1, imm: 8'h00};

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StClear
   } loader_state_e;

   function automatic instr_t boot_word(int idx);
      case (idx)
         0:       boot_word = BootWord0;
         1:       boot_word = BootWord1;
         default: boot_word = '0;
      endcase
   endfunction

endpackage

// File: rtl/prog_mem_loader_if.sv
// Fetch and load handshake bundle between the fetch stage / program loader and the memory.
interface prog_mem_loader_if #(
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned ADDR_W  = 5
);
   logic               fetch_req;
   logic [ADDR_W-1:0]  fetch_addr;
   logic               fetch_valid;
   logic [INSTR_W-1:0] fetch_instr;
   logic               fetch_err;
   logic               load_start;
   logic               load_valid;
   logic [INSTR_W-1:0] load_data;
   logic               load_last;
   logic               load_ready;
   logic               busy;
   logic               load_done;
   logic [ADDR_W:0]    load_count;

   modport master (
      output fetch_req, fetch_addr, load_start, load_valid, load_data, load_last,
      input  fetch_valid, fetch_instr, fetch_err, load_ready, busy, load_done, load_count
   );

   modport slave (
      input  fetch_req, fetch_addr, load_start, load_valid, load_data, load_last,
      output fetch_valid, fetch_instr, fetch_err, load_ready, busy, load_done, load_count
   );
endinterface

// File: rtl/prog_mem_loader_array.sv
// Program word array: resets to the boot image, one write port, one registered read port
// whose output holds when no read is issued.
module prog_mem_loader_array
   import prog_mem_loader_pkg::*;
#(
   parameter int unsigned INSTR_W = InstrWDefault,
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               we_i,
   input  logic [ADDR_W-1:0]  waddr_i,
   input  logic [INSTR_W-1:0] wdata_i,
   input  logic               re_i,
   input  logic [ADDR_W-1:0]  raddr_i,
   output logic [INSTR_W-1:0] rdata_o
);

   localparam logic [ADDR_W:0] DepthW = DEPTH[ADDR_W:0];

   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic [INSTR_W-1:0] mem_d [DEPTH];
   logic [INSTR_W-1:0] rdata_q, rdata_d;
   logic               in_range;

   assign in_range = ({1'b0, raddr_i} < DepthW);

   always_comb begin
      mem_d = mem_q;
      if (we_i) mem_d[waddr_i] = wdata_i;
      rdata_d = rdata_q;
      // Out-of-range reads return a NOP rather than aliasing into the array.
      if (re_i) rdata_d = in_range ? mem_q[raddr_i] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= INSTR_W'(boot_word(i));
         rdata_q <= '0;
      end else begin
         mem_q   <= mem_d;
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem_loader.sv
// Loadable program memory: registered fetch port served only when idle, plus a streaming
// loader that rewrites the array from word 0 and zero-fills whatever the program leaves.
module prog_mem_loader
   import prog_mem_loader_pkg::*;
#(
   parameter int unsigned INSTR_W = InstrWDefault,
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
   input logic              clk,
   input logic              rst_n,
   prog_mem_loader_if.slave bus
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DepthW   = DEPTH[ADDR_W:0];

   loader_state_e      state_q, state_d;
   logic [ADDR_W-1:0]  ptr_q, ptr_d;
   logic [ADDR_W:0]    count_q, count_d;
   logic               done_q, done_d;
   logic               fetch_valid_q, fetch_valid_d;
   logic               fetch_err_q, fetch_err_d;
   logic               we;
   logic [INSTR_W-1:0] wdata;
   logic               fetch_fire;

   // A fetch in the same cycle as load_start still reads the pre-load contents.
   assign fetch_fire    = bus.fetch_req && (state_q == StIdle);
   assign fetch_valid_d = fetch_fire;
   assign fetch_err_d   = fetch_fire && ({1'b0, bus.fetch_addr} >= DepthW);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      done_d  = 1'b0;
      we      = 1'b0;
      wdata   = '0;
      unique case (state_q)
         StIdle: begin
            if (bus.load_start) begin
               state_d = StLoad;
               ptr_d   = '0;
               count_d = '0;
            end
         end
         StLoad: begin
            if (bus.load_valid) begin
               we      = 1'b1;
               wdata   = bus.load_data;
               ptr_d   = ptr_q + 1'b1;
               count_d = count_q + 1'b1;
               if (bus.load_last || (ptr_q == LastAddr)) begin
                  if (ptr_q != LastAddr) begin
                     state_d = StClear;
                  end else begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         StClear: begin
            we    = 1'b1;
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LastAddr) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         ptr_q         <= '0;
         count_q       <= '0;
         done_q        <= 1'b0;
         fetch_valid_q <= 1'b0;
         fetch_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         count_q       <= count_d;
         done_q        <= done_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_err_q   <= fetch_err_d;
      end
   end

   prog_mem_loader_array #(
      .INSTR_W(INSTR_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk    (clk),
      .rst_n  (rst_n),
      .we_i   (we),
      .waddr_i(ptr_q),
      .wdata_i(wdata),
      .re_i   (fetch_fire),
      .raddr_i(bus.fetch_addr),
      .rdata_o(bus.fetch_instr)
   );

   assign bus.fetch_valid = fetch_valid_q;
   assign bus.fetch_err   = fetch_err_q;
   assign bus.load_ready  = (state_q == StLoad);
   assign bus.busy        = (state_q != StIdle);
   assign bus.load_done   = done_q;
   assign bus.load_count  = count_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader: scoreboarded fetches on a 32-word instance,
// out-of-range fetches on a 24-word instance.
module tb_prog_mem_loader;

   typedef struct {
      logic [15:0] instr;
      logic        err;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic [15:0] model [32];
   exp_t sb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   prog_mem_loader_if #(.INSTR_W(16), .ADDR_W(5)) b32 ();
   prog_mem_loader_if #(.INSTR_W(16), .ADDR_W(5)) b24 ();

   prog_mem_loader #(.INSTR_W(16), .DEPTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
   prog_mem_loader #(.INSTR_W(16), .DEPTH(24)) dut24 (.clk(clk), .rst_n(rst_n), .bus(b24));

   // Scoreboard: every fetch_valid on the 32-word instance must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (b32.fetch_valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_fetch_valid got instr=%h at cycle %0d, wanted no response",
                     b32.fetch_instr, cyc);
         end else begin
            e = sb.pop_front();
            if (b32.fetch_instr !== e.instr || b32.fetch_err !== e.err || cyc !== e.cyc) begin
               errors++;
               $display("FAIL fetch_result got instr=%h err=%b cycle=%0d, wanted instr=%h err=%b cycle=%0d",
                        b32.fetch_instr, b32.fetch_err, cyc, e.instr, e.err, e.cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got simulation still running, wanted finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic boot_model();
      for (int i = 0; i < 32; i++) model[i] = 16'h0000;
      model[0] = 16'h2810;
      model[1] = 16'h3900;
   endtask

   task automatic clear_inputs();
      b32.fetch_req = 1'b0; b32.fetch_addr = '0; b32.load_start = 1'b0;
      b32.load_valid = 1'b0; b32.load_data = '0; b32.load_last = 1'b0;
      b24.fetch_req = 1'b0; b24.fetch_addr = '0; b24.load_start = 1'b0;
      b24.load_valid = 1'b0; b24.load_data = '0; b24.load_last = 1'b0;
   endtask

   task automatic fetch32(input logic [4:0] addr);
      exp_t e;
      b32.fetch_req  = 1'b1;
      b32.fetch_addr = addr;
      e.instr = model[addr];
      e.err   = 1'b0;
      e.cyc   = cyc + 1;
      sb.push_back(e);
      step();
      b32.fetch_req = 1'b0;
   endtask

   task automatic drain(input string name);
      repeat (2) step();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain got %0d outstanding responses, wanted 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic start_load();
      b32.load_start = 1'b1;
      step();
      b32.load_start = 1'b0;
   endtask

   task automatic beat(input logic [15:0] d, input logic last);
      b32.load_valid = 1'b1;
      b32.load_data  = d;
      b32.load_last  = last;
      step();
      b32.load_valid = 1'b0;
      b32.load_last  = 1'b0;
   endtask

   task automatic finish_load(input string name, input int exp_cycles, input int exp_count);
      int cycles = 0;
      while (b32.busy === 1'b1 && cycles < 100) begin
         cycles++;
         step();
      end
      checks++;
      if (cycles != exp_cycles) begin
         errors++;
         $display("FAIL %s_clear_cycles got %0d, wanted %0d", name, cycles, exp_cycles);
      end
      checks++;
      if (b32.load_done !== 1'b1 || b32.busy !== 1'b0 || b32.load_count !== 6'(exp_count)) begin
         errors++;
         $display("FAIL %s_done got done=%b busy=%b count=%0d, wanted done=1 busy=0 count=%0d",
                  name, b32.load_done, b32.busy, b32.load_count, exp_count);
      end
      step();
      checks++;
      if (b32.load_done !== 1'b0) begin
         errors++;
         $display("FAIL %s_done_pulse got load_done=%b one cycle later, wanted 0",
                  name, b32.load_done);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      boot_model();
      #12;
      checks++;
      if ({b32.busy, b32.load_done, b32.load_ready, b32.fetch_valid, b32.fetch_err,
           b32.load_count, b32.fetch_instr} !== 27'd0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b done=%b ready=%b valid=%b err=%b count=%0d instr=%h, wanted all 0",
                  b32.busy, b32.load_done, b32.load_ready, b32.fetch_valid, b32.fetch_err,
                  b32.load_count, b32.fetch_instr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      fetch32(5'd0);
      fetch32(5'd1);
      fetch32(5'd31);
      drain("reset_fetch");
   endtask

   task automatic test_load_three();
      start_load();
      checks++;
      if (b32.busy !== 1'b1 || b32.load_ready !== 1'b1 || b32.load_count !== 6'd0) begin
         errors++;
         $display("FAIL three_start got busy=%b ready=%b count=%0d, wanted busy=1 ready=1 count=0",
                  b32.busy, b32.load_ready, b32.load_count);
      end
      beat(16'hAAAA, 1'b0);
      beat(16'h5555, 1'b0);
      beat(16'h1234, 1'b1);
      finish_load("three", 29, 3);
      for (int i = 0; i < 32; i++) model[i] = 16'h0000;
      model[0] = 16'hAAAA;
      model[1] = 16'h5555;
      model[2] = 16'h1234;
      fetch32(5'd2);
      fetch32(5'd3);
      fetch32(5'd1);
      drain("three_fetch");
   endtask

   task automatic test_full_load();
      logic [15:0] w;
      start_load();
      for (int i = 0; i < 32; i++) begin
         w = 16'(i * 16'h0101) ^ 16'hC3A5;
         model[i] = w;
         beat(w, 1'b0);
      end
      finish_load("full", 0, 32);
      fetch32(5'd31);
      fetch32(5'd0);
      drain("full_fetch");
   endtask

   task automatic test_busy_ignored();
      start_load();
      beat(16'h1111, 1'b0);
      b32.load_start = 1'b1;
      b32.fetch_req  = 1'b1;
      b32.fetch_addr = 5'd0;
      step();
      b32.load_start = 1'b0;
      b32.fetch_req  = 1'b0;
      checks++;
      if (b32.fetch_valid !== 1'b0 || b32.load_count !== 6'd1 || b32.load_ready !== 1'b1) begin
         errors++;
         $display("FAIL busy_load got valid=%b count=%0d ready=%b, wanted valid=0 count=1 ready=1",
                  b32.fetch_valid, b32.load_count, b32.load_ready);
      end
      beat(16'h2222, 1'b1);
      b32.fetch_req  = 1'b1;
      b32.fetch_addr = 5'd1;
      step();
      b32.fetch_req = 1'b0;
      checks++;
      if (b32.fetch_valid !== 1'b0 || b32.busy !== 1'b1 || b32.load_ready !== 1'b0) begin
         errors++;
         $display("FAIL busy_clear got valid=%b busy=%b ready=%b, wanted valid=0 busy=1 ready=0",
                  b32.fetch_valid, b32.busy, b32.load_ready);
      end
      finish_load("busy", 29, 2);
      for (int i = 0; i < 32; i++) model[i] = 16'h0000;
      model[0] = 16'h1111;
      model[1] = 16'h2222;
      fetch32(5'd0);
      fetch32(5'd1);
      drain("busy_fetch");
   endtask

   task automatic test_fetch_with_load_start();
      exp_t e;
      b32.fetch_req  = 1'b1;
      b32.fetch_addr = 5'd0;
      b32.load_start = 1'b1;
      e.instr = model[0];
      e.err   = 1'b0;
      e.cyc   = cyc + 1;
      sb.push_back(e);
      step();
      b32.fetch_req  = 1'b0;
      b32.load_start = 1'b0;
      checks++;
      if (b32.busy !== 1'b1) begin
         errors++;
         $display("FAIL overlap_busy got busy=%b, wanted 1", b32.busy);
      end
      beat(16'hBEEF, 1'b1);
      finish_load("overlap", 31, 1);
      for (int i = 0; i < 32; i++) model[i] = 16'h0000;
      model[0] = 16'hBEEF;
      fetch32(5'd0);
      fetch32(5'd1);
      drain("overlap_fetch");
   endtask

   task automatic test_depth24();
      logic [4:0]  addrs [3] = '{5'd0, 5'd24, 5'd23};
      logic [15:0] instrs [3] = '{16'h2810, 16'h0000, 16'h0000};
      logic        errs [3] = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         b24.fetch_req  = 1'b1;
         b24.fetch_addr = addrs[i];
         step();
         checks++;
         if (b24.fetch_valid !== 1'b1 || b24.fetch_err !== errs[i] ||
             b24.fetch_instr !== instrs[i]) begin
            errors++;
            $display("FAIL d24_fetch_%0d got valid=%b err=%b instr=%h, wanted valid=1 err=%b instr=%h",
                     addrs[i], b24.fetch_valid, b24.fetch_err, b24.fetch_instr, errs[i], instrs[i]);
         end
      end
      b24.fetch_req = 1'b0;
      step();
      checks++;
      if (b24.fetch_valid !== 1'b0 || b24.fetch_err !== 1'b0) begin
         errors++;
         $display("FAIL d24_idle got valid=%b err=%b, wanted 0 0", b24.fetch_valid, b24.fetch_err);
      end
   endtask

   task automatic test_reset_midload();
      start_load();
      beat(16'hAAAA, 1'b0);
      beat(16'hBBBB, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if (b32.busy !== 1'b0 || b32.load_done !== 1'b0 || b32.load_ready !== 1'b0) begin
         errors++;
         $display("FAIL midload_reset got busy=%b done=%b ready=%b, wanted 0 0 0",
                  b32.busy, b32.load_done, b32.load_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++;
      if (b32.load_done !== 1'b0 || b32.busy !== 1'b0) begin
         errors++;
         $display("FAIL midload_after got done=%b busy=%b, wanted 0 0", b32.load_done, b32.busy);
      end
      boot_model();
      fetch32(5'd0);
      fetch32(5'd1);
      fetch32(5'd2);
      drain("midload_fetch");
   endtask

   initial begin
      test_reset();
      test_load_three();
      test_full_load();
      test_busy_ignored();
      test_fetch_with_load_start();
      test_depth24();
      test_reset_midload();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
